// File: rtl/team_06_echo_sequencer.sv
// Echo effect sequencer: records each dry sample, optionally reads back a delayed
// sample through the SRAM stage, and mixes dry and delayed audio into one output.
module team_06_echo_sequencer #(
    parameter int TIMEOUT = 32,
    parameter int REC_MIN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sampleTick,
    input  logic [7:0]  audioIn,
    input  logic [2:0]  effect,
    input  logic [7:0]  delayAudio,
    input  logic        goodData,
    input  logic        busySRAM,
    output logic        record,
    output logic        search,
    output logic [12:0] offset,
    output logic [7:0]  effectAudioIn,
    output logic [7:0]  audioOut,
    output logic        sampleValid,
    output logic        overrun
);

    localparam int CNT_MAX = (TIMEOUT > REC_MIN) ? TIMEOUT : REC_MIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] REC_MIN_C  = CNT_W'(REC_MIN);
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       MIDSCALE   = 8'd128;

    typedef enum logic [2:0] {
        IDLE, REC, REC_WAIT, SRCH, SRCH_WAIT, SETTLE, MIX
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       dry_q, dry_d;
    logic [7:0]       wet_q, wet_d;
    logic [7:0]       eaud_q, eaud_d;
    logic [7:0]       out_q, out_d;
    logic [2:0]       eff_q, eff_d;
    logic [2:0]       eff_prev_q, eff_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             ovr_q, ovr_d;
    logic             echo_sel;

    // 9-bit sum halved: the carry becomes the MSB, so the average never overflows.
    function automatic logic [7:0] mix_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:1];
    endfunction

    assign echo_sel = (eff_q == 3'd1) || (eff_q == 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (sampleTick) state_d = REC;
            REC:       state_d = REC_WAIT;
            REC_WAIT:  if ((cnt_q >= REC_MIN_C) && !busySRAM)
                           state_d = (echo_sel && goodData) ? SRCH : MIX;
            SRCH:      state_d = SRCH_WAIT;
            SRCH_WAIT: if ((seen_q && !busySRAM) || (cnt_q == TMO_LAST_C))
                           state_d = SETTLE;
            SETTLE:    state_d = MIX;
            MIX:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        record      = (state_q == REC);
        search      = (state_q == SRCH);
        sampleValid = (state_q == MIX);
    end

    always_comb begin
        dry_d      = dry_q;
        wet_d      = wet_q;
        eaud_d     = eaud_q;
        out_d      = out_q;
        eff_d      = eff_q;
        eff_prev_d = effect;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        ovr_d      = ovr_q;
        case (state_q)
            IDLE: begin
                if (sampleTick) begin
                    dry_d  = audioIn;
                    eaud_d = audioIn;
                    eff_d  = effect;
                end
                if (effect != eff_prev_q) ovr_d = 1'b0;
            end
            REC:       cnt_d = '0;
            REC_WAIT: begin
                // Saturate at REC_MIN so a long busy stretch cannot wrap the counter.
                if (cnt_q < REC_MIN_C) cnt_d = cnt_q + 1'b1;
                if (state_d == MIX) wet_d = MIDSCALE;
            end
            SRCH: begin
                cnt_d  = '0;
                seen_d = 1'b0;
            end
            SRCH_WAIT: begin
                cnt_d  = cnt_q + 1'b1;
                seen_d = seen_q | busySRAM;
            end
            SETTLE:    wet_d = delayAudio;
            default:   ;
        endcase
        if ((state_q != IDLE) && sampleTick) ovr_d = 1'b1;
        // Output is loaded on entry to MIX so it is already valid with sampleValid.
        if (state_d == MIX) out_d = echo_sel ? mix_avg(dry_q, wet_d) : dry_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dry_q      <= MIDSCALE;
            wet_q      <= MIDSCALE;
            eaud_q     <= MIDSCALE;
            out_q      <= MIDSCALE;
            eff_q      <= 3'd0;
            eff_prev_q <= 3'd0;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            dry_q      <= dry_d;
            wet_q      <= wet_d;
            eaud_q     <= eaud_d;
            out_q      <= out_d;
            eff_q      <= eff_d;
            eff_prev_q <= eff_prev_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        case (eff_q)
            3'd1:    offset = 13'd2048;
            3'd2:    offset = 13'd8191;
            default: offset = 13'd0;
        endcase
    end

    assign effectAudioIn = eaud_q;
    assign audioOut      = out_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_team_06_echo_sequencer.sv
// Directed bench for the echo sequencer: bypass, echo handshake, cached-word timeout,
// unclean memory, overrun behaviour and reset in the middle of a sequence.
module tb_team_06_echo_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sampleTick;
    logic [7:0]  audioIn;
    logic [2:0]  effect;
    logic [7:0]  delayAudio;
    logic        goodData;
    logic        busySRAM;
    logic        record;
    logic        search;
    logic [12:0] offset;
    logic [7:0]  effectAudioIn;
    logic [7:0]  audioOut;
    logic        sampleValid;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;
    int rec_cnt     = 0;
    int srch_cnt    = 0;
    int val_cnt     = 0;
    int both_cnt    = 0;

    team_06_echo_sequencer #(.TIMEOUT(32), .REC_MIN(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .sampleTick    (sampleTick),
        .audioIn       (audioIn),
        .effect        (effect),
        .delayAudio    (delayAudio),
        .goodData      (goodData),
        .busySRAM      (busySRAM),
        .record        (record),
        .search        (search),
        .offset        (offset),
        .effectAudioIn (effectAudioIn),
        .audioOut      (audioOut),
        .sampleValid   (sampleValid),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (record)           rec_cnt  <= rec_cnt + 1;
        if (search)           srch_cnt <= srch_cnt + 1;
        if (sampleValid)      val_cnt  <= val_cnt + 1;
        if (record && search) both_cnt <= both_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] a, input logic [2:0] e);
        repeat (2) step();
        audioIn    = a;
        effect     = e;
        sampleTick = 1'b1;
        step();
        sampleTick = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (sampleValid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("valid_seen", {31'd0, sampleValid}, 32'd1);
    endtask

    task automatic wait_search(input int budget, output int n);
        n = 0;
        while (search !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("search_seen", {31'd0, search}, 32'd1);
    endtask

    initial begin
        int n;
        int r0, s0, v0;
        rst        = 1'b1;
        sampleTick = 1'b0;
        audioIn    = 8'd0;
        effect     = 3'd0;
        delayAudio = 8'd0;
        goodData   = 1'b0;
        busySRAM   = 1'b0;
        repeat (3) step();

        chk("rst_record",  {31'd0, record}, 32'd0);
        chk("rst_search",  {31'd0, search}, 32'd0);
        chk("rst_valid",   {31'd0, sampleValid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_audioOut", {24'd0, audioOut}, 32'd128);
        chk("rst_effAudio", {24'd0, effectAudioIn}, 32'd128);
        chk("rst_offset",  {19'd0, offset}, 32'd0);
        rst = 1'b0;

        // bypass
        r0 = rec_cnt; s0 = srch_cnt; v0 = val_cnt;
        tick(8'd200, 3'd0);
        chk("byp_record_now", {31'd0, record}, 32'd1);
        wait_valid(20, n);
        chk("byp_audioOut", {24'd0, audioOut}, 32'd200);
        chk("byp_effAudio", {24'd0, effectAudioIn}, 32'd200);
        step();
        chk("byp_records", rec_cnt - r0, 32'd1);
        chk("byp_searches", srch_cnt - s0, 32'd0);
        chk("byp_valids", val_cnt - v0, 32'd1);

        // short echo with busy handshake
        goodData   = 1'b1;
        delayAudio = 8'd50;
        tick(8'd100, 3'd1);
        wait_search(20, n);
        chk("echo_offset", {19'd0, offset}, 32'd2048);
        chk("echo_no_record", {31'd0, record}, 32'd0);
        step();
        busySRAM = 1'b1;
        step();
        step();
        busySRAM = 1'b0;
        wait_valid(20, n);
        chk("echo_audioOut", {24'd0, audioOut}, 32'd75);
        chk("echo_offset_mix", {19'd0, offset}, 32'd2048);

        // cached word: busy never rises, wait runs the full timeout
        delayAudio = 8'd255;
        tick(8'd255, 3'd2);
        wait_search(20, n);
        chk("tmo_offset", {19'd0, offset}, 32'd8191);
        wait_valid(60, n);
        chk("tmo_search_to_valid", n, 32'd34);
        chk("tmo_audioOut", {24'd0, audioOut}, 32'd255);
        chk("tmo_offset_mix", {19'd0, offset}, 32'd8191);

        // memory not clean: no search, wet is midscale
        goodData   = 1'b0;
        delayAudio = 8'd50;
        s0 = srch_cnt;
        tick(8'd0, 3'd1);
        wait_valid(20, n);
        chk("dirty_audioOut", {24'd0, audioOut}, 32'd64);
        chk("dirty_offset", {19'd0, offset}, 32'd2048);
        step();
        chk("dirty_searches", srch_cnt - s0, 32'd0);

        // overrun: second tick while busy, effect change while busy
        goodData = 1'b1;
        v0 = val_cnt;
        tick(8'd10, 3'd0);
        step();
        effect     = 3'd1;
        audioIn    = 8'd99;
        sampleTick = 1'b1;
        step();
        sampleTick = 1'b0;
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_offset_held", {19'd0, offset}, 32'd0);
        wait_valid(20, n);
        chk("ovr_audioOut", {24'd0, audioOut}, 32'd10);
        chk("ovr_effAudio", {24'd0, effectAudioIn}, 32'd10);
        repeat (4) step();
        chk("ovr_one_valid", val_cnt - v0, 32'd1);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        effect = 3'd3;
        repeat (2) step();
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        // reset in the middle of SRCH_WAIT
        tick(8'd77, 3'd2);
        wait_search(20, n);
        repeat (3) step();
        sampleTick = 1'b1;
        step();
        sampleTick = 1'b0;
        chk("mid_ovr_set", {31'd0, overrun}, 32'd1);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_audioOut", {24'd0, audioOut}, 32'd128);
        chk("mid_effAudio", {24'd0, effectAudioIn}, 32'd128);
        chk("mid_offset", {19'd0, offset}, 32'd0);
        chk("mid_overrun", {31'd0, overrun}, 32'd0);
        chk("mid_valid", {31'd0, sampleValid}, 32'd0);
        chk("mid_search", {31'd0, search}, 32'd0);
        step();
        rst = 1'b0;
        r0 = rec_cnt; s0 = srch_cnt; v0 = val_cnt;
        repeat (40) step();
        chk("post_rst_valids", val_cnt - v0, 32'd0);
        chk("post_rst_records", rec_cnt - r0, 32'd0);
        chk("post_rst_searches", srch_cnt - s0, 32'd0);

        chk("record_search_overlap", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
